dafx_adc_frame_router: RTL and testbench

//   Parametrised ADC front-end for the DAFX core.
//   - Accepts the interleaved multi-channel ADC sample stream (valid/ready/last).
//   - Deinterleaves it into NR_OF_ADC_CHANNELS_P parallel channels, updated atomically per frame.
//   - Generates the frame strobe (fs_strobe) for the mixer.
//   - Detects framing errors and tracks per-channel signed min/max peaks.
//   - Raises a frame-counted, programmable-period IRQ.

---
 rtl/dafx_adc_frame_router.sv | 175 +++++++++++++++++
 tb/tb_dafx_adc_frame_router.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dafx_adc_frame_router.sv
// rtl/dafx_adc_frame_router.sv - ADC frame deinterleaver with framing check, peak tracking and frame IRQ
module dafx_adc_frame_router #(
    parameter int AUDIO_WIDTH_P        = 24,
    parameter int NR_OF_ADC_CHANNELS_P = 2,
    parameter int IRQ_COUNTER_WIDTH_P  = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic        [AUDIO_WIDTH_P-1:0]       adc_data,
    input  logic                                  adc_valid,
    output logic                                  adc_ready,
    input  logic                                  adc_last,
    output logic signed [AUDIO_WIDTH_P-1:0]       channel_data [NR_OF_ADC_CHANNELS_P],
    output logic                                  fs_strobe,
    input  logic        [IRQ_COUNTER_WIDTH_P-1:0] cr_irq_period,
    input  logic                                  cmd_clear_peaks,
    input  logic                                  cmd_clear_frame_error,
    output logic signed [AUDIO_WIDTH_P-1:0]       sr_max_amplitude [NR_OF_ADC_CHANNELS_P],
    output logic signed [AUDIO_WIDTH_P-1:0]       sr_min_amplitude [NR_OF_ADC_CHANNELS_P],
    output logic                                  sr_frame_error,
    output logic        [31:0]                    sr_frame_count,
    output logic                                  irq
);

    localparam int N  = NR_OF_ADC_CHANNELS_P;
    localparam int W  = AUDIO_WIDTH_P;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(N - 1);

    typedef enum logic {
        RUN,
        RESYNC
    } state_t;

    state_t                        state;
    logic        [CW-1:0]          ch;
    logic signed [W-1:0]           staging  [N];
    logic signed [W-1:0]           pub_word [N];
    logic        [IRQ_COUNTER_WIDTH_P-1:0] divider;

    logic accept;
    logic at_last_ch;
    logic in_run;
    logic publish;
    logic frame_err;

    assign accept     = adc_valid && adc_ready;
    assign at_last_ch = (ch == LAST_CH);
    assign in_run     = (state == RUN);
    assign publish    = accept && in_run && adc_last && at_last_ch;
    // Short frame (last too early) or long frame (final channel without last)
    assign frame_err  = accept && in_run && (adc_last != at_last_ch);

    // Frame being published: staged channels plus the beat currently carrying last
    always_comb begin
        for (int i = 0; i < N; i++) begin
            pub_word[i] = staging[i];
        end
        pub_word[N-1] = $signed(adc_data);
    end

    // Handshake, channel index, staging registers and framing FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            adc_ready <= 1'b0;
            state     <= RUN;
            ch        <= '0;
            for (int i = 0; i < N; i++) begin
                staging[i] <= '0;
            end
        end else begin
            adc_ready <= 1'b1;
            case (state)
                RUN: begin
                    if (accept) begin
                        if (adc_last) begin
                            ch <= '0;
                        end else if (at_last_ch) begin
                            ch    <= '0;
                            state <= RESYNC;
                        end else begin
                            for (int i = 0; i < N; i++) begin
                                if (ch == CW'(i)) begin
                                    staging[i] <= $signed(adc_data);
                                end
                            end
                            ch <= ch + 1'b1;
                        end
                    end
                end
                RESYNC: begin
                    if (accept && adc_last) begin
                        ch    <= '0;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Publish channel data, frame strobe, frame counter and IRQ divider
    always_ff @(posedge clk) begin
        if (rst) begin
            fs_strobe      <= 1'b0;
            irq            <= 1'b0;
            sr_frame_count <= '0;
            divider        <= '0;
            for (int i = 0; i < N; i++) begin
                channel_data[i] <= '0;
            end
        end else begin
            fs_strobe <= publish;
            irq       <= 1'b0;
            if (publish) begin
                for (int i = 0; i < N; i++) begin
                    channel_data[i] <= pub_word[i];
                end
                sr_frame_count <= sr_frame_count + 32'd1;
                if (cr_irq_period != '0) begin
                    if (divider >= cr_irq_period - 1'b1) begin
                        irq     <= 1'b1;
                        divider <= '0;
                    end else begin
                        divider <= divider + 1'b1;
                    end
                end
            end
            if (cr_irq_period == '0) begin
                divider <= '0;
            end
        end
    end

    // Signed running peaks; a clear coinciding with a publish restarts from zero and this frame
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                sr_max_amplitude[i] <= '0;
                sr_min_amplitude[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (publish) begin
                    if (cmd_clear_peaks) begin
                        sr_max_amplitude[i] <= (pub_word[i] > 0) ? pub_word[i] : '0;
                        sr_min_amplitude[i] <= (pub_word[i] < 0) ? pub_word[i] : '0;
                    end else begin
                        if (pub_word[i] > sr_max_amplitude[i]) begin
                            sr_max_amplitude[i] <= pub_word[i];
                        end
                        if (pub_word[i] < sr_min_amplitude[i]) begin
                            sr_min_amplitude[i] <= pub_word[i];
                        end
                    end
                end else if (cmd_clear_peaks) begin
                    sr_max_amplitude[i] <= '0;
                    sr_min_amplitude[i] <= '0;
                end
            end
        end
    end

    // Sticky framing-error flag; a new error wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_frame_error <= 1'b0;
        end else if (frame_err) begin
            sr_frame_error <= 1'b1;
        end else if (cmd_clear_frame_error) begin
            sr_frame_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dafx_adc_frame_router.sv
// tb/tb_dafx_adc_frame_router.sv - scoreboard bench for dafx_adc_frame_router with N=1, 2 and 4 instances
module tb_dafx_adc_frame_router;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        adc_last = 1'b0;
    logic [31:0] cr_irq_period = '0;
    logic        cmd_clear_peaks = 1'b0;
    logic        cmd_clear_frame_error = 1'b0;

    logic        ready_w [3];
    logic        fs_w    [3];
    logic        irq_w   [3];
    logic        err_w   [3];
    logic [31:0] cnt_w   [3];
    logic [23:0] obs_ch  [3][4];
    logic [23:0] obs_mx  [3][4];
    logic [23:0] obs_mn  [3][4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int N = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        logic signed [23:0] ch_w [N];
        logic signed [23:0] mx_w [N];
        logic signed [23:0] mn_w [N];

        dafx_adc_frame_router #(
            .AUDIO_WIDTH_P(24),
            .NR_OF_ADC_CHANNELS_P(N),
            .IRQ_COUNTER_WIDTH_P(32)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .adc_data(adc_data),
            .adc_valid(adc_valid),
            .adc_ready(ready_w[g]),
            .adc_last(adc_last),
            .channel_data(ch_w),
            .fs_strobe(fs_w[g]),
            .cr_irq_period(cr_irq_period),
            .cmd_clear_peaks(cmd_clear_peaks),
            .cmd_clear_frame_error(cmd_clear_frame_error),
            .sr_max_amplitude(mx_w),
            .sr_min_amplitude(mn_w),
            .sr_frame_error(err_w[g]),
            .sr_frame_count(cnt_w[g]),
            .irq(irq_w[g])
        );

        for (genvar i = 0; i < 4; i++) begin : g_pad
            if (i < N) begin : g_on
                assign obs_ch[g][i] = ch_w[i];
                assign obs_mx[g][i] = mx_w[i];
                assign obs_mn[g][i] = mn_w[i];
            end else begin : g_off
                assign obs_ch[g][i] = '0;
                assign obs_mx[g][i] = '0;
                assign obs_mn[g][i] = '0;
            end
        end
    end

    typedef struct {
        logic [3:0][23:0] ch;
        logic [3:0][23:0] mx;
        logic [3:0][23:0] mn;
        logic [31:0]      cnt;
        logic             err;
        logic             irq;
    } exp_t;

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    int n_checks = 0;
    int n_errors = 0;
    int irq_seen [3];

    // Reference model state: frames are judged by their length between last beats
    int               flen  [3];
    logic [3:0][23:0] fbuf  [3];
    logic [3:0][23:0] m_ch  [3];
    logic [3:0][23:0] m_mx  [3];
    logic [3:0][23:0] m_mn  [3];
    logic [31:0]      m_cnt [3];
    logic [31:0]      m_div [3];
    logic             m_err [3];

    function automatic int nof(int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    function automatic int q_size(int k);
        if (k == 0) return q0.size();
        if (k == 1) return q1.size();
        return q2.size();
    endfunction

    task automatic q_push(int k, exp_t e);
        if (k == 0) q0.push_back(e);
        else if (k == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic q_pop(int k, output exp_t e);
        if (k == 0) e = q0.pop_front();
        else if (k == 1) e = q1.pop_front();
        else e = q2.pop_front();
    endtask

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d (N=%0d): got %h expected %h at %0t", nm, k, nof(k), act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            flen[k]  = 0;
            fbuf[k]  = '0;
            m_ch[k]  = '0;
            m_mx[k]  = '0;
            m_mn[k]  = '0;
            m_cnt[k] = '0;
            m_div[k] = '0;
            m_err[k] = 1'b0;
        end
    endtask

    task automatic model_cycle(bit acc, logic [23:0] d, bit last, bit clrp, bit clre);
        for (int k = 0; k < 3; k++) begin
            int n;
            bit pub;
            bit er;
            bit irq_e;
            exp_t e;
            n = nof(k);
            pub = 0;
            er = 0;
            irq_e = 0;
            if (acc) begin
                if (flen[k] < 4) fbuf[k][flen[k]] = d;
                flen[k]++;
                if (last) begin
                    if (flen[k] == n) pub = 1;
                    else if (flen[k] < n) er = 1;
                    flen[k] = 0;
                end else if (flen[k] == n) begin
                    er = 1;
                end
            end
            if (pub) begin
                for (int i = 0; i < n; i++) begin
                    int s;
                    s = int'($signed(fbuf[k][i]));
                    m_ch[k][i] = fbuf[k][i];
                    if (clrp) begin
                        m_mx[k][i] = (s > 0) ? fbuf[k][i] : 24'd0;
                        m_mn[k][i] = (s < 0) ? fbuf[k][i] : 24'd0;
                    end else begin
                        if (s > int'($signed(m_mx[k][i]))) m_mx[k][i] = fbuf[k][i];
                        if (s < int'($signed(m_mn[k][i]))) m_mn[k][i] = fbuf[k][i];
                    end
                end
                m_cnt[k] = m_cnt[k] + 32'd1;
                if (cr_irq_period != 0) begin
                    if (m_div[k] >= cr_irq_period - 32'd1) begin
                        irq_e = 1;
                        m_div[k] = '0;
                    end else begin
                        m_div[k] = m_div[k] + 32'd1;
                    end
                end
            end else if (clrp) begin
                m_mx[k] = '0;
                m_mn[k] = '0;
            end
            if (cr_irq_period == 0) m_div[k] = '0;
            m_err[k] = er | (m_err[k] & ~clre);
            if (pub) begin
                e.ch = m_ch[k];
                e.mx = m_mx[k];
                e.mn = m_mn[k];
                e.cnt = m_cnt[k];
                e.err = m_err[k];
                e.irq = irq_e;
                q_push(k, e);
            end
        end
    endtask

    // Scoreboard monitor: every fs_strobe pops one expected frame per instance
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                exp_t e;
                if (fs_w[k]) begin
                    if (q_size(k) == 0) begin
                        chk("unexpected_fs_strobe", k, 32'd1, 32'd0);
                    end else begin
                        q_pop(k, e);
                        for (int i = 0; i < 4; i++) begin
                            chk($sformatf("channel_data[%0d]", i), k, 32'(obs_ch[k][i]), 32'(e.ch[i]));
                            chk($sformatf("max[%0d]", i), k, 32'(obs_mx[k][i]), 32'(e.mx[i]));
                            chk($sformatf("min[%0d]", i), k, 32'(obs_mn[k][i]), 32'(e.mn[i]));
                        end
                        chk("frame_count", k, cnt_w[k], e.cnt);
                        chk("frame_error_at_publish", k, 32'(err_w[k]), 32'(e.err));
                        chk("irq", k, 32'(irq_w[k]), 32'(e.irq));
                        if (irq_w[k]) irq_seen[k]++;
                    end
                end else begin
                    chk("irq_without_strobe", k, 32'(irq_w[k]), 32'd0);
                    if (q_size(k) != 0) begin
                        chk("missing_fs_strobe", k, 32'd0, 32'd1);
                        q_pop(k, e);
                    end
                end
            end
        end
    end

    task automatic check_state(string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_frame_error"}, k, 32'(err_w[k]), 32'(m_err[k]));
            chk({tag, "_frame_count"}, k, cnt_w[k], m_cnt[k]);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("%s_ch[%0d]", tag, i), k, 32'(obs_ch[k][i]), 32'(m_ch[k][i]));
                chk($sformatf("%s_max[%0d]", tag, i), k, 32'(obs_mx[k][i]), 32'(m_mx[k][i]));
                chk($sformatf("%s_min[%0d]", tag, i), k, 32'(obs_mn[k][i]), 32'(m_mn[k][i]));
            end
        end
    endtask

    task automatic beat(input logic [23:0] d, input bit last, input bit clrp, input bit clre);
        bit acc;
        bit cp;
        bit ce;
        acc = 0;
        adc_data = d;
        adc_valid = 1'b1;
        adc_last = last;
        cmd_clear_peaks = clrp;
        cmd_clear_frame_error = clre;
        for (int t = 0; t < 8; t++) begin
            acc = ready_w[0];
            cp = cmd_clear_peaks;
            ce = cmd_clear_frame_error;
            @(posedge clk);
            model_cycle(acc, d, last, cp, ce);
            @(negedge clk);
            cmd_clear_peaks = 1'b0;
            cmd_clear_frame_error = 1'b0;
            if (acc) break;
        end
        if (!acc) chk("beat_accept_timeout", 0, 32'(acc), 32'd1);
        adc_valid = 1'b0;
        adc_last = 1'b0;
    endtask

    task automatic idle(input int n, input bit clrp, input bit clre);
        for (int t = 0; t < n; t++) begin
            cmd_clear_peaks = clrp;
            cmd_clear_frame_error = clre;
            @(posedge clk);
            model_cycle(0, '0, 0, clrp, clre);
            @(negedge clk);
            cmd_clear_peaks = 1'b0;
            cmd_clear_frame_error = 1'b0;
        end
    endtask

    task automatic frame2(input logic [23:0] a, input logic [23:0] b);
        beat(a, 0, 0, 0);
        beat(b, 1, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        adc_valid = 1'b0;
        adc_last = 1'b0;
        cmd_clear_peaks = 1'b0;
        cmd_clear_frame_error = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_adc_ready", k, 32'(ready_w[k]), 32'd0);
            chk("reset_fs_strobe", k, 32'(fs_w[k]), 32'd0);
            chk("reset_irq", k, 32'(irq_w[k]), 32'd0);
        end
        check_state("reset");
        rst = 1'b0;
    endtask

    initial begin
        int irq_before;
        @(negedge clk);
        do_reset();

        // Basic stereo frame
        frame2(24'h100000, 24'hF00000);
        idle(1, 0, 0);
        chk("t1_ch0", 1, 32'(obs_ch[1][0]), 32'h100000);
        chk("t1_ch1", 1, 32'(obs_ch[1][1]), 32'hF00000);
        chk("t1_max0", 1, 32'(obs_mx[1][0]), 32'h100000);
        chk("t1_min1", 1, 32'(obs_mn[1][1]), 32'hF00000);
        chk("t1_count", 1, cnt_w[1], 32'd1);
        check_state("t1");

        // Short frame then good frame
        beat(24'h000123, 1, 0, 0);
        idle(2, 0, 0);
        chk("t2_error", 1, 32'(err_w[1]), 32'd1);
        chk("t2_count_unchanged", 1, cnt_w[1], 32'd1);
        check_state("t2");
        frame2(24'h000011, 24'h000022);
        idle(1, 0, 0);

        // Long frame: three beats, last only on the third
        idle(1, 0, 1);
        beat(24'h0000AA, 0, 0, 0);
        beat(24'h0000BB, 0, 0, 0);
        beat(24'h0000CC, 1, 0, 0);
        idle(1, 0, 0);
        chk("t3_error", 1, 32'(err_w[1]), 32'd1);
        chk("t3_ch0_kept", 1, 32'(obs_ch[1][0]), 32'h000011);
        frame2(24'h000033, 24'h000044);
        idle(1, 0, 0);
        chk("t3_ch0_new", 1, 32'(obs_ch[1][0]), 32'h000033);
        check_state("t3");

        // IRQ divider
        do_reset();
        cr_irq_period = 32'd4;
        irq_before = irq_seen[1];
        for (int f = 0; f < 10; f++) frame2(24'($urandom), 24'($urandom));
        idle(1, 0, 0);
        chk("t4_irq_count_p4", 1, 32'(irq_seen[1] - irq_before), 32'd2);
        cr_irq_period = 32'd0;
        irq_before = irq_seen[1];
        for (int f = 0; f < 3; f++) frame2(24'($urandom), 24'($urandom));
        idle(1, 0, 0);
        chk("t4_irq_count_p0", 1, 32'(irq_seen[1] - irq_before), 32'd0);
        cr_irq_period = 32'd4;
        for (int f = 0; f < 3; f++) frame2(24'($urandom), 24'($urandom));
        cr_irq_period = 32'd2;
        irq_before = irq_seen[1];
        frame2(24'($urandom), 24'($urandom));
        idle(1, 0, 0);
        chk("t4_irq_after_lowering", 1, 32'(irq_seen[1] - irq_before), 32'd1);

        // Peak clear coinciding with publish, error set wins over clear
        do_reset();
        frame2(24'd100, 24'hFFFFFE);
        beat(24'hFFFFFB, 0, 0, 0);
        beat(24'd7, 1, 1, 0);
        idle(1, 0, 0);
        chk("t5_max0", 1, 32'(obs_mx[1][0]), 32'd0);
        chk("t5_min0", 1, 32'(obs_mn[1][0]), 32'hFFFFFB);
        beat(24'd5, 1, 0, 1);
        idle(1, 0, 0);
        chk("t5_err_set_wins", 1, 32'(err_w[1]), 32'd1);
        check_state("t5");

        // Reset mid-frame
        beat(24'h00ABCD, 0, 0, 0);
        do_reset();
        frame2(24'h012345, 24'h06789A);
        idle(1, 0, 0);
        chk("t6_ch0", 1, 32'(obs_ch[1][0]), 32'h012345);
        chk("t6_ch1", 1, 32'(obs_ch[1][1]), 32'h06789A);
        check_state("t6");

        // Randomized frames of mixed lengths against all three channel counts
        for (int f = 0; f < 300; f++) begin
            int len;
            len = $urandom_range(1, 5);
            if ($urandom_range(0, 29) == 0) cr_irq_period = 32'($urandom_range(0, 5));
            for (int j = 0; j < len; j++) begin
                beat(24'($urandom), j == len - 1, $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);
            end
        end
        idle(2, 0, 0);
        check_state("random_end");
        for (int k = 0; k < 3; k++) chk("scoreboard_drained", k, 32'(q_size(k)), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
